// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared encodings and arbitration helper for the UART TX frame arbiter
//
// Purpose:
//   Grant encodings, FSM state encoding and the frame-level arbitration
//   decision shared by the arbiter top and anything that decodes its grant.
//
// Contents:
//   GNT_NONE / GNT_A / GNT_B   grant bus values (idle / A owns / B owns)
//   ST_IDLE / ST_SEND / ST_WAIT_EO and state_t
//   arb_pick()                 which requester wins a free transmitter
package uart_tx_arbiter_pkg;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_A    = 2'b01;
    localparam logic [1:0] GNT_B    = 2'b10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_WAIT_EO = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        SEND    = ST_SEND,
        WAIT_EO = ST_WAIT_EO
    } state_t;

    // B (command responses) normally wins a tie; A (telemetry) wins only
    // once it has been passed over the configured number of times.
    function automatic logic [1:0] arb_pick(
        input logic a_req,
        input logic b_req,
        input logic a_starved
    );
        logic [1:0] g;
        g = GNT_NONE;
        if (a_req && b_req) begin
            g = a_starved ? GNT_A : GNT_B;
        end else if (b_req) begin
            g = GNT_B;
        end else if (a_req) begin
            g = GNT_A;
        end
        return g;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_period_tick_gen.sv
// rtl/uart_tx_arbiter_period_tick_gen.sv - free-running period counter with a one-cycle tick
//
// Purpose:
//   Counts 0..PERIOD-1 and wraps. The tick is high for exactly the cycle in
//   which the count equals PERIOD-1, so the first tick after reset release
//   appears PERIOD-1 cycles after the first cycle out of reset. Reusable by
//   any sender that needs a fixed transmit cadence.
//
// Ports:
//   i_clk    in   1  system clock
//   i_rst    in   1  synchronous, active-high reset (count returns to 0)
//   o_tick   out  1  one-cycle pulse every PERIOD cycles
module uart_tx_arbiter_period_tick_gen #(
    parameter int PERIOD = 6000000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = w_wrap;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-level arbiter sharing one UART transmitter between two byte streams
//
// Purpose:
//   Owns the UART start/data interface. Requester A (periodic telemetry)
//   and requester B (command responses/acks) present bytes with a
//   req/ack handshake; whole frames are granted, bytes are never
//   interleaved. Also produces the telemetry period tick and flags a tick
//   that lands while an A frame is still on the wire.
//
// Ports:
//   i_clk          in   1  system clock
//   i_rst          in   1  synchronous, active-high reset
//   i_a_req        in   1  A has a byte available (held until acked)
//   i_a_data       in   8  A byte
//   i_a_last       in   1  A byte is last of its frame
//   o_a_ack        out  1  one-cycle pulse: A byte consumed
//   i_b_req        in   1  B has a byte available (held until acked)
//   i_b_data       in   8  B byte
//   i_b_last       in   1  B byte is last of its frame
//   o_b_ack        out  1  one-cycle pulse: B byte consumed
//   o_tx_data      out  8  byte to UART, stable from o_tx_st until i_tx_eo
//   o_tx_st        out  1  one-cycle start pulse to UART
//   i_tx_eo        in   1  one-cycle end-of-byte pulse from UART
//   o_period_tick  out  1  one-cycle telemetry trigger every PERIOD cycles
//   o_grant        out  2  01 = A owns, 10 = B owns, 00 = idle
//   o_err_to       out  1  one-cycle pulse on timeout abort
//   o_overrun      out  1  one-cycle pulse: period tick while A owns the UART
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int PERIOD     = 6000000,
    parameter int TIMEOUT    = 100000,
    parameter int STARVE_LIM = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_a_req,
    input  logic [7:0] i_a_data,
    input  logic       i_a_last,
    output logic       o_a_ack,
    input  logic       i_b_req,
    input  logic [7:0] i_b_data,
    input  logic       i_b_last,
    output logic       o_b_ack,
    output logic [7:0] o_tx_data,
    output logic       o_tx_st,
    input  logic       i_tx_eo,
    output logic       o_period_tick,
    output logic [1:0] o_grant,
    output logic       o_err_to,
    output logic       o_overrun
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    state_t        r_state;
    logic [1:0]    r_grant;
    logic [TW-1:0] r_timer;
    logic [SW-1:0] r_starve;
    logic          r_last;
    logic [7:0]    r_tx_data;
    logic          r_tx_st;
    logic          r_a_ack;
    logic          r_b_ack;
    logic          r_err_to;

    logic          w_tick;
    logic          w_own_req;
    logic [7:0]    w_own_data;
    logic          w_own_last;
    logic          w_timeout;
    logic          w_starved;
    logic [1:0]    w_pick;

    uart_tx_arbiter_period_tick_gen #(
        .PERIOD (PERIOD)
    ) u_period (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    // Byte source multiplexed by the current owner; an idle grant reads as
    // "no request" so SEND can never pick up a byte from a non-owner.
    always_comb begin
        w_own_req  = 1'b0;
        w_own_data = 8'h00;
        w_own_last = 1'b0;
        if (r_grant == GNT_A) begin
            w_own_req  = i_a_req;
            w_own_data = i_a_data;
            w_own_last = i_a_last;
        end else if (r_grant == GNT_B) begin
            w_own_req  = i_b_req;
            w_own_data = i_b_data;
            w_own_last = i_b_last;
        end
    end

    assign w_timeout = (r_timer == TIMER_LAST);
    assign w_starved = (r_starve == STARVE_MAX);
    assign w_pick    = arb_pick(i_a_req, i_b_req, w_starved);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_grant   <= GNT_NONE;
            r_timer   <= '0;
            r_starve  <= '0;
            r_last    <= 1'b0;
            r_tx_data <= 8'h00;
            r_tx_st   <= 1'b0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_err_to  <= 1'b0;
        end else begin
            r_tx_st  <= 1'b0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_err_to <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (w_pick != GNT_NONE) begin
                        r_grant <= w_pick;
                        r_state <= SEND;
                        if (w_pick == GNT_A) begin
                            r_starve <= '0;
                        end else if (i_a_req) begin
                            // B only beats a pending A while A is below the
                            // limit, so this never runs past STARVE_MAX.
                            r_starve <= r_starve + 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (w_own_req) begin
                        r_tx_data <= w_own_data;
                        r_tx_st   <= 1'b1;
                        r_a_ack   <= (r_grant == GNT_A);
                        r_b_ack   <= (r_grant == GNT_B);
                        r_last    <= w_own_last;
                        r_timer   <= '0;
                        r_state   <= WAIT_EO;
                    end else if (w_timeout) begin
                        r_err_to <= 1'b1;
                        r_grant  <= GNT_NONE;
                        r_last   <= 1'b0;
                        r_timer  <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                WAIT_EO: begin
                    // A completed byte takes priority over a timeout that
                    // would expire in the same cycle.
                    if (i_tx_eo) begin
                        r_timer <= '0;
                        if (r_last) begin
                            r_grant <= GNT_NONE;
                            r_last  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= SEND;
                        end
                    end else if (w_timeout) begin
                        r_err_to <= 1'b1;
                        r_grant  <= GNT_NONE;
                        r_last   <= 1'b0;
                        r_timer  <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                default: begin
                    r_grant <= GNT_NONE;
                    r_timer <= '0;
                    r_last  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_tx_data     = r_tx_data;
    assign o_tx_st       = r_tx_st;
    assign o_a_ack       = r_a_ack;
    assign o_b_ack       = r_b_ack;
    assign o_err_to      = r_err_to;
    assign o_grant       = r_grant;
    assign o_period_tick = w_tick;
    assign o_overrun     = w_tick && (r_grant == GNT_A);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for the UART TX frame arbiter
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int PERIOD     = 20;
    localparam int TIMEOUT    = 16;
    localparam int STARVE_LIM = 2;
    localparam int EO_DLY     = 5;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_a_req, i_a_last, i_b_req, i_b_last, i_tx_eo;
    logic [7:0] i_a_data, i_b_data;
    logic       o_a_ack, o_b_ack, o_tx_st, o_period_tick, o_err_to, o_overrun;
    logic [7:0] o_tx_data;
    logic [1:0] o_grant;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .PERIOD     (PERIOD),
        .TIMEOUT    (TIMEOUT),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_a_req       (i_a_req),
        .i_a_data      (i_a_data),
        .i_a_last      (i_a_last),
        .o_a_ack       (o_a_ack),
        .i_b_req       (i_b_req),
        .i_b_data      (i_b_data),
        .i_b_last      (i_b_last),
        .o_b_ack       (o_b_ack),
        .o_tx_data     (o_tx_data),
        .o_tx_st       (o_tx_st),
        .i_tx_eo       (i_tx_eo),
        .o_period_tick (o_period_tick),
        .o_grant       (o_grant),
        .o_err_to      (o_err_to),
        .o_overrun     (o_overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] a_q[$];
    logic [8:0] b_q[$];
    logic [9:0] sb[$];

    int drop_eo = 0;
    int exp_err = 0;
    int n_st = 0, n_aack = 0, n_back = 0, n_tick = 0, n_ovr = 0, n_err_seen = 0;
    int cyc = 0, rc = 0, t_ref = 0, t_st = 0;
    bit busy = 1'b0;

    logic s_a, s_b, s_st;
    int   eo_cnt = 0;
    logic [9:0] exp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_req(input logic [1:0] g, input logic [7:0] d, input logic last);
        if (g == GNT_A) a_q.push_back({last, d});
        else            b_q.push_back({last, d});
    endtask

    task automatic exp_tx(input logic [1:0] g, input logic [7:0] d);
        sb.push_back({g, d});
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_grant"},  o_grant,       2'b00);
        check({tag, "_tx_st"},  o_tx_st,       1'b0);
        check({tag, "_tx_data"}, o_tx_data,    8'h00);
        check({tag, "_a_ack"},  o_a_ack,       1'b0);
        check({tag, "_b_ack"},  o_b_ack,       1'b0);
        check({tag, "_err_to"}, o_err_to,      1'b0);
        check({tag, "_tick"},   o_period_tick, 1'b0);
        check({tag, "_overrun"}, o_overrun,    1'b0);
    endtask

    task automatic wait_done(input string name, input int lim);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && a_q.size() == 0 && b_q.size() == 0 &&
                o_grant == GNT_NONE && !o_tx_st) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wait_st(input string name, input int base, input int lim);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(posedge clk); #1;
            if (n_st > base) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    // Requester and UART models: sample DUT outputs mid-cycle, drive inputs
    // just after the next rising edge.
    initial begin
        i_a_req = 1'b0; i_a_data = 8'h00; i_a_last = 1'b0;
        i_b_req = 1'b0; i_b_data = 8'h00; i_b_last = 1'b0;
        i_tx_eo = 1'b0;
        forever begin
            @(negedge clk);
            s_a  = o_a_ack;
            s_b  = o_b_ack;
            s_st = o_tx_st;
            @(posedge clk); #1;
            if (s_a && a_q.size() > 0) void'(a_q.pop_front());
            if (s_b && b_q.size() > 0) void'(b_q.pop_front());
            i_a_req = (a_q.size() > 0);
            if (a_q.size() > 0) {i_a_last, i_a_data} = a_q[0];
            else                {i_a_last, i_a_data} = 9'h000;
            i_b_req = (b_q.size() > 0);
            if (b_q.size() > 0) {i_b_last, i_b_data} = b_q[0];
            else                {i_b_last, i_b_data} = 9'h000;
            if (s_st) begin
                if (drop_eo > 0) begin
                    drop_eo--;
                    eo_cnt = 0;
                end else begin
                    eo_cnt = EO_DLY;
                end
            end else if (eo_cnt > 0) begin
                eo_cnt--;
            end
            i_tx_eo = (eo_cnt == 1);
        end
    end

    // Monitor: pops the scoreboard on every transmitted byte.
    always @(negedge clk) begin
        if (i_rst) begin
            rc   = 0;
            busy = 1'b0;
        end else begin
            if (o_period_tick || (rc % PERIOD == PERIOD - 1)) begin
                check("period_tick", o_period_tick, (rc % PERIOD == PERIOD - 1));
                if (o_period_tick) n_tick++;
            end
            if (o_period_tick || o_overrun) begin
                check("overrun", o_overrun, o_period_tick && (o_grant == GNT_A));
                if (o_overrun) n_ovr++;
            end
            if (i_tx_eo) begin
                busy  = 1'b0;
                t_ref = cyc;
            end
            if (o_grant == GNT_NONE && (i_a_req || i_b_req)) t_ref = cyc;
            if (o_tx_st || o_a_ack || o_b_ack) begin
                if (o_tx_st) n_st++;
                if (o_a_ack) n_aack++;
                if (o_b_ack) n_back++;
                check("ack_with_tx_st", o_tx_st, 1'b1);
                check("no_double_tx_st", busy, 1'b0);
                check("tx_st_latency", cyc - t_ref, 2);
                busy = 1'b1;
                t_st = cyc;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_tx_st: got data %02h grant %0d, required no transmission",
                             o_tx_data, o_grant);
                end else begin
                    exp_e = sb.pop_front();
                    check("tx_data", o_tx_data, exp_e[7:0]);
                    check("grant",   o_grant,   exp_e[9:8]);
                    check("a_ack",   o_a_ack,   exp_e[9:8] == GNT_A);
                    check("b_ack",   o_b_ack,   exp_e[9:8] == GNT_B);
                end
            end
            if (o_err_to) begin
                busy = 1'b0;
                n_err_seen++;
                if (exp_err == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_err_to: got err_to=1, required 0");
                end else begin
                    exp_err--;
                    check("err_to_delay", cyc - t_st, TIMEOUT);
                    check("grant_after_abort", o_grant, GNT_NONE);
                end
            end
            rc++;
        end
        cyc++;
    end

    initial begin
        #300000;
        n_errors++;
        $display("FAIL watchdog: simulation still running, required completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    int base;

    initial begin
        i_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero_outs("reset");
        @(posedge clk); #1;
        i_rst = 1'b0;

        // 1: A-only frame, spans the first period tick -> overrun
        push_req(GNT_A, 8'hF7, 1'b0); push_req(GNT_A, 8'h40, 1'b0); push_req(GNT_A, 8'h12, 1'b1);
        exp_tx(GNT_A, 8'hF7); exp_tx(GNT_A, 8'h40); exp_tx(GNT_A, 8'h12);
        wait_done("t1_frame_done", 200);
        check("t1_tx_st_count", n_st, 3);
        check("t1_a_ack_count", n_aack, 3);
        check("t1_b_ack_count", n_back, 0);
        check("t1_grant_idle", o_grant, GNT_NONE);
        check("t1_overrun_seen", (n_ovr > 0), 1'b1);

        // 2: simultaneous requests, B streams frames -> B, B, A, B
        push_req(GNT_A, 8'hA0, 1'b0); push_req(GNT_A, 8'hA1, 1'b1);
        push_req(GNT_B, 8'hB0, 1'b0); push_req(GNT_B, 8'hB1, 1'b1);
        push_req(GNT_B, 8'hC0, 1'b0); push_req(GNT_B, 8'hC1, 1'b1);
        push_req(GNT_B, 8'hD0, 1'b1);
        exp_tx(GNT_B, 8'hB0); exp_tx(GNT_B, 8'hB1);
        exp_tx(GNT_B, 8'hC0); exp_tx(GNT_B, 8'hC1);
        exp_tx(GNT_A, 8'hA0); exp_tx(GNT_A, 8'hA1);
        exp_tx(GNT_B, 8'hD0);
        wait_done("t2_starve_done", 400);

        // 3: A arrives mid B frame -> no interleave
        base = n_st;
        push_req(GNT_B, 8'h31, 1'b0); push_req(GNT_B, 8'h32, 1'b0); push_req(GNT_B, 8'h33, 1'b1);
        exp_tx(GNT_B, 8'h31); exp_tx(GNT_B, 8'h32); exp_tx(GNT_B, 8'h33);
        exp_tx(GNT_A, 8'h44);
        wait_st("t3_first_byte", base, 50);
        push_req(GNT_A, 8'h44, 1'b1);
        wait_done("t3_done", 200);

        // 4: UART silent after first byte -> timeout abort, then re-arbitrate
        drop_eo = 1;
        exp_err = 1;
        push_req(GNT_A, 8'h11, 1'b0); push_req(GNT_A, 8'h22, 1'b1);
        exp_tx(GNT_A, 8'h11); exp_tx(GNT_A, 8'h22);
        wait_done("t4_done", 200);
        check("t4_err_to_consumed", exp_err, 0);
        check("t4_err_to_count", n_err_seen, 1);

        // 6: reset while waiting for tx_eo
        base = n_st;
        push_req(GNT_B, 8'h5A, 1'b0); push_req(GNT_B, 8'hA5, 1'b1);
        exp_tx(GNT_B, 8'h5A);
        wait_st("t6_first_byte", base, 50);
        i_rst = 1'b1;
        a_q.delete();
        b_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_zero_outs("t6_reset");
        @(posedge clk); #1;
        i_rst = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_no_tx_after_eo", n_st, base + 1);
        check("t6_grant_idle", o_grant, GNT_NONE);
        check("t6_sb_empty", sb.size(), 0);

        repeat (40) @(negedge clk);
        check("tick_count_min", (n_tick >= 3), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
